lsu_bus_master: RTL

//  Parametrised load/store unit for the MEM stage: replaces single-cycle RAM access with a

---
 rtl/lsu_bus_master.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_master.sv
// lsu_bus_master -- MEM-stage load/store unit driving a multi-cycle ce/ack bus.
//
// Performs byte/half/word loads and stores, plus dword when DATA_W=64. It
// steers little-endian lanes, sign- or zero-extends load data and rejects
// misaligned or illegal accesses without starting a bus cycle.
//
// Optional feature macro: LSU_TIMEOUT_EN. When it is defined, a REQ-state
// cycle counter aborts an access that gets no ack within TIMEOUT_CYC cycles.
//
// Handshakes:
//   - req_valid_i presents one op. EX/MEM holds it stable while stallreq_o=1.
//     The op is accepted in the IDLE cycle where req_valid_i=1.
//   - ram_ce_o is held with constant ram_* until a cycle with ram_ack_i=1.
//     ram_ack_i may arrive in the first ce cycle, and ram_data_i is sampled
//     in that cycle. An ack outside REQ is ignored.
//   - rsp_valid_o is a one-cycle completion pulse. rsp_* are 0 otherwise.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid_i .. req_rd_i          memory op from EX/MEM
//   stallreq_o                       stall request to ctrl
//   rsp_valid_o, rsp_wreg_o,
//   rsp_wd_o, rsp_wdata_o            completion / write-back
//   misalign_o, bus_err_o            completion status flags
//   ram_ce_o .. ram_data_o           bus request (registered)
//   ram_data_i, ram_ack_i            bus response
//   dbg_state                        current FSM state, for debug/checkers
module lsu_bus_master #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int RADDR_W     = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  input  logic [RADDR_W-1:0]    req_rd_i,
  output logic                  stallreq_o,
  output logic                  rsp_valid_o,
  output logic                  rsp_wreg_o,
  output logic [RADDR_W-1:0]    rsp_wd_o,
  output logic [DATA_W-1:0]     rsp_wdata_o,
  output logic                  misalign_o,
  output logic                  bus_err_o,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [DATA_W/8-1:0]   ram_sel_o,
  output logic [DATA_W-1:0]     ram_data_o,
  input  logic [DATA_W-1:0]     ram_data_i,
  input  logic                  ram_ack_i,
  output logic [1:0]            dbg_state
);
  localparam int SEL_W = DATA_W / 8;
  localparam int OFF_W = $clog2(SEL_W);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
    $error("lsu_bus_master: DATA_W must be 32 or 64");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("lsu_bus_master: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_next;

  // Request decode, evaluated on the live request in the IDLE cycle.
  logic [OFF_W-1:0]  off;
  logic              misalign;
  logic [SEL_W-1:0]  mask;
  logic [DATA_W-1:0] wrep;
  assign off = req_addr_i[OFF_W-1:0];

  always_comb begin
    misalign = 1'b0;
    mask     = '0;
    wrep     = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        mask = SEL_W'(8'h01);
        wrep = {SEL_W{req_wdata_i[7:0]}};
      end
      2'b01: begin
        misalign = req_addr_i[0];
        mask     = SEL_W'(8'h03);
        wrep     = {(SEL_W/2){req_wdata_i[15:0]}};
      end
      2'b10: begin
        misalign = |req_addr_i[1:0];
        mask     = SEL_W'(8'h0F);
        wrep     = {(SEL_W/4){req_wdata_i[31:0]}};
      end
      default: begin
        // A dword only exists on a 64-bit bus.
        misalign = (DATA_W != 64) || (|req_addr_i[2:0]);
        mask     = '1;
        wrep     = req_wdata_i;
      end
    endcase
  end

  // Latched request attributes.
  logic               we_q, uns_q, mis_q;
  logic [1:0]         size_q;
  logic [OFF_W-1:0]   off_q;
  logic [RADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]  rdata_q;

  // Load data: shift the addressed byte to lane 0, then extend to full width.
  logic [DATA_W-1:0] shifted, ext;
  assign shifted = ram_data_i >> {off_q, 3'b000};

  always_comb begin
    ext = shifted;
    case (size_q)
      2'b00: begin
        ext = DATA_W'(shifted[7:0]);
        if (!uns_q && shifted[7]) ext = ext | ~DATA_W'(8'hFF);
      end
      2'b01: begin
        ext = DATA_W'(shifted[15:0]);
        if (!uns_q && shifted[15]) ext = ext | ~DATA_W'(16'hFFFF);
      end
      2'b10: begin
        ext = DATA_W'(shifted[31:0]);
        if (!uns_q && shifted[31]) ext = ext | ~DATA_W'(32'hFFFF_FFFF);
      end
      default: ext = shifted;
    endcase
  end

  logic timeout;
  logic err;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  // cnt holds the number of REQ cycles already completed. The cycle where it
  // equals TIMEOUT_CYC-1 is the last one allowed. An ack in that cycle still
  // completes the access normally.
  assign timeout = (state == REQ) && !ram_ack_i && (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst || state != REQ) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                              err_q <= 1'b0;
    else if (state == IDLE && req_valid_i) err_q <= 1'b0;
    else if (timeout)                     err_q <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // FSM: state register plus next-state logic.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid_i) state_next = misalign ? RESP : REQ;
      REQ:     if (ram_ack_i || timeout) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch and bus-side registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      mis_q      <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
      ram_ce_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_sel_o  <= '0;
      ram_data_o <= '0;
    end else begin
      if (state == IDLE && req_valid_i) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        mis_q   <= misalign;
        size_q  <= req_size_i;
        off_q   <= off;
        rd_q    <= req_rd_i;
        rdata_q <= '0;
        if (!misalign) begin
          ram_ce_o   <= 1'b1;
          ram_we_o   <= req_we_i;
          ram_addr_o <= {req_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
          ram_sel_o  <= mask << off;
          ram_data_o <= wrep;
        end
      end
      if (state == REQ && (ram_ack_i || timeout)) begin
        ram_ce_o   <= 1'b0;
        ram_we_o   <= 1'b0;
        ram_addr_o <= '0;
        ram_sel_o  <= '0;
        ram_data_o <= '0;
        if (ram_ack_i) rdata_q <= ext;
      end
    end
  end

  // Response side. Every rsp_* output is forced to 0 outside the RESP pulse.
  assign stallreq_o  = (state == IDLE && req_valid_i) || (state == REQ);
  assign rsp_valid_o = (state == RESP);
  assign rsp_wreg_o  = rsp_valid_o && !we_q && !mis_q && !err;
  assign rsp_wd_o    = rsp_valid_o ? rd_q : '0;
  assign rsp_wdata_o = rsp_wreg_o ? rdata_q : '0;
  assign misalign_o  = rsp_valid_o && mis_q;
  assign bus_err_o   = rsp_valid_o && err;
  assign dbg_state   = state;

endmodule
